// File: rtl/hex_display_pkg.sv
// Shared constants and types for the hex display controller: the nibble type,
// the blank pattern and the active-low 7-segment lookup table (bit 0 = segment a).
package hex_display_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry k holds the active-low pattern for hex value k, packed F down to 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder; output is active-low with bit 0 = segment a.
module seg7_hex_decode
  import hex_display_pkg::*;
(
  input  nibble_t    digit,
  input  logic       unused_tie,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment display controller with masked digit writes, leading-zero
// blanking, display enable and registered outputs. Blinking is built only when
// HEX_DISPLAY_BLINK_EN is defined; otherwise no blink state exists and the phase reads 0.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [NUM_DIGITS-1:0]   i_wr_mask,
  input  logic [4*NUM_DIGITS-1:0] i_wr_data,
  input  logic                    i_blink_we,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic                    i_lzb,
  input  logic                    i_disp_en,
  output logic [7*NUM_DIGITS-1:0] o_seg,
  output logic                    o_blink_phase
);

  nibble_t                 digit_q [NUM_DIGITS];
  logic [6:0]              dec_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blink_off;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    zero_run;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= 4'h0;
    end else if (i_wr_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (i_wr_mask[k]) digit_q[k] <= i_wr_data[4*k +: 4];
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_hex_decode u_dec (
      .digit      (digit_q[g]),
      .unused_tie (1'b0),
      .seg        (dec_seg[g])
    );
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  logic [CNT_W-1:0]      blink_cnt;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] blink_mask_q;

  // The mask load deliberately leaves the counter and phase alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      blink_mask_q <= '0;
    end else begin
      if (blink_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (i_blink_we) blink_mask_q <= i_blink_mask;
    end
  end

  assign blink_off     = blink_phase ? blink_mask_q : '0;
  assign o_blink_phase = blink_phase;
`else
  logic unused_blink;

  assign unused_blink  = ^{i_blink_we, i_blink_mask, BLINK_CYCLES[0]};
  assign blink_off     = '0;
  assign o_blink_phase = 1'b0;
`endif

  // Walk from the most significant digit down; zero_run stays set while every
  // digit seen so far is zero. Digit 0 is exempt so a zero value still shows "0".
  always_comb begin
    seg_next = '1;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (digit_q[k] == 4'h0);
      if (!i_disp_en || (i_lzb && zero_run && (k != 0)) || blink_off[k])
        seg_next[7*k +: 7] = SEG_BLANK;
      else
        seg_next[7*k +: 7] = dec_seg[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_seg <= '1;
    else          o_seg <= seg_next;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized self-checking bench for hex_display_ctrl against a behavioural model
// that tracks digit values, blink mask and elapsed edges since reset.
module tb_hex_display_ctrl;

  localparam int ND = 8;
  localparam int BC = 4;

  localparam logic [6:0] REF_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, wr_en, blink_we, lzb, disp_en;
  logic [ND-1:0]   wr_mask, blink_mask;
  logic [4*ND-1:0] wr_data;
  logic [7*ND-1:0] seg;
  logic            blink_phase;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]    m_digit [ND];
  logic [ND-1:0] m_mask;
  int            n_edges;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_CYCLES(BC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_en      (wr_en),
    .i_wr_mask    (wr_mask),
    .i_wr_data    (wr_data),
    .i_blink_we   (blink_we),
    .i_blink_mask (blink_mask),
    .i_lzb        (lzb),
    .i_disp_en    (disp_en),
    .o_seg        (seg),
    .o_blink_phase(blink_phase)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Phase after n edges since reset: toggles once per BC edges.
  function automatic int ref_phase(input int n);
`ifdef HEX_DISPLAY_BLINK_EN
    return (n / BC) % 2;
`else
    return 0;
`endif
  endfunction

  function automatic logic [7*ND-1:0] ref_seg();
    int            msd;
    logic          blank;
    logic [7*ND-1:0] r;
    msd = 0;
    r   = '1;
    for (int k = 0; k < ND; k++) if (m_digit[k] != 4'h0) msd = k;
    for (int k = 0; k < ND; k++) begin
      blank = !disp_en || (lzb && k > msd) || (ref_phase(n_edges) == 1 && m_mask[k]);
      r[7*k +: 7] = blank ? 7'b1111111 : REF_SEG[m_digit[k]];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) m_digit[k] = 4'h0;
    m_mask  = '0;
    n_edges = 0;
  endtask

  task automatic cycle();
    logic [7*ND-1:0] e;
    e = ref_seg();
    @(posedge clk);
    #1;
    if (wr_en)
      for (int k = 0; k < ND; k++) if (wr_mask[k]) m_digit[k] = wr_data[4*k +: 4];
`ifdef HEX_DISPLAY_BLINK_EN
    if (blink_we) m_mask = blink_mask;
`endif
    n_edges++;
    chk("seg", 64'(seg), 64'(e));
    chk("phase", 64'(blink_phase), 64'(ref_phase(n_edges)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_seg", 64'(seg), 64'({ND{7'b1111111}}));
    chk("rst_phase", 64'(blink_phase), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", 64'(seg), 64'({ND{7'b1111111}}));
    rst_n = 1'b1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    blink_we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_mask = '0; wr_data = '0;
    blink_we = 1'b0; blink_mask = '0; lzb = 1'b0; disp_en = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Release with all-zero digits
    cycle();
    chk("rel_zero", 64'(seg), 64'({ND{7'b1000000}}));

    // Masked write: digit0=3, digit2=A, one edge of latency
    wr_en = 1'b1; wr_mask = 8'h05; wr_data = 32'h0000_0A03;
    cycle();
    chk("wr_lat", 64'(seg[6:0]), 64'(7'b1000000));
    idle();
    cycle();
    chk("wr_d0", 64'(seg[6:0]), 64'(7'b0110000));
    chk("wr_d1", 64'(seg[13:7]), 64'(7'b1000000));
    chk("wr_d2", 64'(seg[20:14]), 64'(7'b0001000));

    // Leading-zero blanking on 0x00000120, then all zero
    wr_en = 1'b1; wr_mask = 8'hFF; wr_data = 32'h0000_0120; lzb = 1'b1;
    cycle();
    idle();
    cycle();
    chk("lzb_hi", 64'(seg[55:21]), 64'({5{7'b1111111}}));
    chk("lzb_d2", 64'(seg[20:14]), 64'(7'b1111001));
    chk("lzb_d1", 64'(seg[13:7]), 64'(7'b0100100));
    chk("lzb_d0", 64'(seg[6:0]), 64'(7'b1000000));
    wr_en = 1'b1; wr_data = 32'h0;
    cycle();
    idle();
    cycle();
    chk("lzb_zero", 64'(seg), 64'({{7{7'b1111111}}, 7'b1000000}));
    lzb = 1'b0;

    // Blink on digit 0
    wr_en = 1'b1; wr_mask = 8'hFF; wr_data = 32'h1234_5678;
    blink_we = 1'b1; blink_mask = 8'h01;
    cycle();
    idle();
    repeat (4 * BC) cycle();

    // Reset while phase is 1
    for (int i = 0; i < 2 * BC && ref_phase(n_edges) == 0; i++) cycle();
`ifdef HEX_DISPLAY_BLINK_EN
    chk("ph1_reach", 64'(blink_phase), 64'd1);
`endif
    do_reset();
    blink_we = 1'b1; blink_mask = 8'h01;
    cycle();
    idle();
    repeat (3 * BC) cycle();

    // Randomized traffic
    for (int it = 0; it < 500; it++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_mask = 8'($urandom);
      for (int k = 0; k < ND; k++)
        wr_data[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      blink_we   = ($urandom_range(0, 7) == 0);
      blink_mask = 8'($urandom);
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      disp_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) begin
        idle();
        do_reset();
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of 7-segment digits driven (range 1..8).
REQ-002 SHALL have parameter BLINK_CYCLES, default 25_000_000, clock cycles per blink half-period (minimum 2).
REQ-003 SHALL have ports: i_clk  in  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have: i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have: i_wr_en  in  1  write strobe for digit values.
REQ-006 SHALL have: i_wr_mask  in  NUM_DIGITS  per-digit write enable (bit k selects digit k).
REQ-007 SHALL have: i_wr_data  in  4*NUM_DIGITS  nibble k = new value of digit k.
REQ-008 SHALL have: i_blink_we  in  1  blink-mask load strobe; i_blink_mask  in  NUM_DIGITS  digits to blink.
REQ-009 SHALL have: i_lzb  in  1  leading-zero blanking enable; i_disp_en  in  1  display enable.
REQ-010 SHALL have: o_seg  out  7*NUM_DIGITS  active-low segments, bits [7k+6:7k] = digit k, bit 0 = segment a.
REQ-011 SHALL have: o_blink_phase  out  1  current blink phase (1 = blinking digits off).

Function
REQ-012 SHALL hold one 4-bit value register per digit; on i_wr_en, digit k SHALL load nibble k only where i_wr_mask[k]=1.
REQ-013 SHALL load the blink-mask register from i_blink_mask on i_blink_we; simultaneous i_wr_en and i_blink_we SHALL both take effect.
REQ-014 SHALL decode 0-F to standard active-low patterns (0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110).
REQ-015 SHALL register o_seg; a write in cycle N SHALL appear on o_seg after edge N+1 (latency 1 cycle after the write edge).
REQ-016 SHALL blank a digit (1111111) when i_disp_en=0, regardless of all other state.
REQ-017 With i_lzb=1, digit k SHALL blank when its value and all higher digits' values are 0; digit 0 SHALL never blank by LZB (value 0 shows "0").
REQ-018 Blink counter SHALL count 0..BLINK_CYCLES-1, wrap to 0 and toggle the blink phase on wrap.
REQ-019 With blink phase 1, digits with blink-mask bit set SHALL blank; other digits unaffected.
REQ-020 Loading a new blink mask SHALL NOT reset the blink counter or phase.
REQ-021 i_lzb and i_disp_en SHALL be sampled combinationally into the output register (effect after one edge).

Reset
REQ-022 On i_rst_n=0, all digit values SHALL be 0, blink mask 0, blink counter 0, blink phase 0.
REQ-023 During reset o_seg SHALL be all-ones (all blank) and o_blink_phase 0; reset mid-count SHALL restart blinking from phase 0.
REQ-024 First edge after release SHALL present decoded state (with i_disp_en=1, i_lzb=0: all digits "0").

Configuration
REQ-025 Macro HEX_DISPLAY_BLINK_EN SHALL gate the blink feature.
REQ-026 Defined: REQ-018..REQ-020 apply as written.
REQ-027 Undefined: no blink counter or mask register; i_blink_we/i_blink_mask ignored; o_blink_phase tied 0; digits never blink.

Structure
REQ-028 Shared package hex_display_pkg SHALL hold the 16-entry segment-pattern constants, SEG_BLANK (7'b1111111) and the digit-nibble typedef.
REQ-029 Decode SHALL be one sub-module seg7_hex_decode (4-bit in, 7-bit active-low out), instantiated NUM_DIGITS times.

Verification
REQ-030 Reset, release, i_disp_en=1, i_lzb=0 -> every digit 1000000; o_blink_phase=0.
REQ-031 i_wr_en, mask 0000_0101, data 0x0000_0A03 -> digit0=0110000, digit2=0001000, others unchanged; change visible one edge later.
REQ-032 Digits 0x0000_0120 with i_lzb=1 -> digits 3..7 blank, digit2=1111001, digit1=0100100, digit0=1000000; all-zero value -> only digit0 "0".
REQ-033 BLINK_CYCLES=4, blink mask 0000_0001 -> digit0 alternates blank/shown every 4 cycles, phase toggles at counter wrap; others steady.
REQ-034 Assert i_rst_n=0 mid-blink while phase=1 -> o_seg all ones immediately, after release phase=0, counter restarts from 0.
REQ-035 Build without HEX_DISPLAY_BLINK_EN, same stimulus as REQ-033 -> digit0 never blanks, o_blink_phase constantly 0.
